ifetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the control unit in the multi-cycle core.
- Owns the fetch PC and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned words in a small prefetch FIFO and presents the head word on `I` with `W_IR_valid`.
- Pops the head word on `write_ir`. Flushes and redirects on `write_pc` with target `pc_next`.

---
 rtl/ifetch_pkg.sv | 17 +
 rtl/ifetch_fifo.sv | 44 ++++
 rtl/ifetch_unit.sv | 114 +++++++++++
 tb/tb_ifetch_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fifo_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// DEPTH-entry prefetch FIFO; head is combinational from storage, count registered.
// clear dominates push and pop.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fifo_entry_t   push_data,
  input  logic          pop,
  input  logic          clear,
  output logic [CW-1:0] count,
  output fifo_entry_t   head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fifo_entry_t   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage carries no reset; a full FIFO may push into the slot being popped.
  always_ff @(posedge clk) begin
    if (push && !clear && !rst) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: owns the fetch PC, one outstanding imem read, prefetch FIFO to the IR.
// IFETCH_ALIGN_CHECK_EN makes misaligned redirects raise a sticky fetch_fault.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write_ir,
  input  logic        write_pc,
  input  logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] I,
  output logic        W_IR_valid,
  output logic [31:0] pc_cur,
  output logic        fetch_fault
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] fa;
  logic [ADDR_W-1:0] tgt;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_nxt;
  fifo_entry_t       head;
  fifo_entry_t       push_data;
  logic              push;
  logic              pop;
  logic              fault_q;
  logic              fault_nxt;
  logic              fetch_ok;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign tgt       = pc_next;
  assign fault_nxt = write_pc ? (pc_next[1:0] != 2'b00) : fault_q;

  always_ff @(posedge clk) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= fault_nxt;
  end
`else
  logic unused_pc_low;
  assign unused_pc_low = ^pc_next[1:0];
  assign tgt       = {pc_next[31:2], 2'b00};
  assign fault_nxt = 1'b0;
  assign fault_q   = 1'b0;
`endif

  assign fetch_fault = fault_q;

  assign push      = (state == ST_REQ) && imem_ack && !write_pc;
  assign pop       = write_ir && W_IR_valid && !write_pc;
  assign push_data = '{instr: imem_rdata, pc: imem_addr};

  // Occupancy after this edge decides whether the next request may launch.
  assign count_nxt = write_pc ? '0 : count + CW'(push) - CW'(pop);
  assign fetch_ok  = !fault_nxt && (count_nxt < CW'(DEPTH));

  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .clear     (write_pc),
    .count     (count),
    .head      (head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      fa        <= RESET_PC;
      imem_addr <= RESET_PC;
    end else begin
      if (write_pc)  fa <= tgt;
      else if (push) fa <= fa + PC_STEP;

      case (state)
        ST_IDLE: begin
          if (!write_pc && fetch_ok) begin
            state     <= ST_REQ;
            imem_addr <= fa;
          end
        end
        ST_REQ: begin
          if (imem_ack) begin
            state <= fetch_ok ? ST_REQ : ST_IDLE;
            if (fetch_ok) imem_addr <= write_pc ? tgt : fa + PC_STEP;
          end else if (write_pc) begin
            // Handshake stays up on the old address; the reply is thrown away.
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (imem_ack) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign imem_req   = (state != ST_IDLE);
  assign W_IR_valid = (count != '0);
  assign I          = W_IR_valid ? head.instr : '0;
  assign pc_cur     = W_IR_valid ? head.pc : '0;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios plus randomized traffic against a queue-based model.
module tb_ifetch_unit;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, write_ir, write_pc, imem_req, imem_ack, W_IR_valid, fetch_fault;
  logic [31:0] pc_next, imem_addr, imem_rdata, I, pc_cur;

  ifetch_unit #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .write_ir    (write_ir),
    .write_pc    (write_pc),
    .pc_next     (pc_next),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .I           (I),
    .W_IR_valid  (W_IR_valid),
    .pc_cur      (pc_cur),
    .fetch_fault (fetch_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  // Reference model: buffered words, next fetch address, the one open request.
  ent_t        q[$];
  logic [31:0] m_fa, m_req_addr;
  bit          m_out, m_disc, m_fault;

  int          total, bad, cyc;
  int          lat_min, lat_max, mwait;
  bit          mbusy, rand_data, stray_en;
  logic [31:0] req_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] log_at(input int k);
    return (k < req_log.size()) ? req_log[k] : 32'hDEAD_BEEF;
  endfunction

  task automatic model_edge();
    bit          done, good;
    logic [31:0] t;
    ent_t        e;
    if (rst) begin
      q.delete();
      m_fa = RST_PC; m_out = 0; m_disc = 0; m_fault = 0;
      return;
    end
    done = m_out && imem_ack;
    good = done && !m_disc;
    if (write_pc) begin
      q.delete();
`ifdef IFETCH_ALIGN_CHECK_EN
      m_fault = (pc_next % 4) != 0;
      t = pc_next;
`else
      t = pc_next & 32'hFFFF_FFFC;
`endif
      m_fa = t;
      if (m_out && !imem_ack) m_disc = 1;
    end else begin
      if (write_ir && q.size() > 0) q.delete(0);
      if (good) begin
        e.instr = imem_rdata; e.pc = m_req_addr;
        q.push_back(e);
        m_fa = m_req_addr + 32'd4;
      end
    end
    if (done) m_out = 0;
    // A fresh request launches unless a drained reply or a redirect consumed this edge.
    if (!m_out && !m_fault && q.size() < DEPTH && (good || (!done && !write_pc))) begin
      m_out = 1; m_req_addr = m_fa; m_disc = 0;
    end
  endtask

  task automatic compare();
    chk("valid",  W_IR_valid, q.size() != 0);
    chk("instr",  I,      (q.size() != 0) ? q[0].instr : 32'h0);
    chk("pc_cur", pc_cur, (q.size() != 0) ? q[0].pc : 32'h0);
    chk("req",    imem_req, m_out);
    if (m_out) chk("addr", imem_addr, m_req_addr);
    chk("fault",  fetch_fault, m_fault);
  endtask

  task automatic step();
    if (rst) begin
      imem_ack = 0; mbusy = 0; imem_rdata = 0;
    end else if (imem_req) begin
      if (!mbusy) begin
        mbusy = 1;
        mwait = $urandom_range(lat_max, lat_min);
        req_log.push_back(imem_addr);
      end
      if (mwait == 0) begin
        imem_ack = 1; mbusy = 0;
        imem_rdata = rand_data ? $urandom : (imem_addr ^ 32'hA5A5_0000);
      end else begin
        imem_ack = 0; mwait--; imem_rdata = $urandom;
      end
    end else begin
      mbusy = 0;
      imem_ack = stray_en && ($urandom_range(9, 0) == 0);
      imem_rdata = $urandom;
    end
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    compare();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic reset_dut(input int lmin, input int lmax);
    rst = 1; write_ir = 0; write_pc = 0; pc_next = 0;
    step(); step();
    rst = 0; lat_min = lmin; lat_max = lmax;
    req_log.delete();
  endtask

  initial begin
    int          n, stab_err;
    bit          found, pending, got;
    logic [31:0] first_pc;
    int          pop_cyc[$];
    logic [31:0] pop_pc[$];

    total = 0; bad = 0; cyc = 0;
    rst = 1; write_ir = 0; write_pc = 0; pc_next = 0;
    imem_ack = 0; imem_rdata = 0; mbusy = 0; mwait = 0;
    lat_min = 0; lat_max = 0; rand_data = 0; stray_en = 0;

    // Reset state, then 1-cycle memory and no consumer: FIFO fills with 0x0 and 0x4.
    reset_dut(1, 1);
    chk("rst_req",   imem_req, 1'b0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_instr", I, 32'h0);
    chk("rst_valid", W_IR_valid, 1'b0);
    chk("rst_pc",    pc_cur, 32'h0);
    chk("rst_fault", fetch_fault, 1'b0);
    run(10);
    chk("t1_nreq",  req_log.size(), 2);
    chk("t1_req0",  log_at(0), 32'h0);
    chk("t1_req1",  log_at(1), 32'h4);
    chk("t1_idle",  imem_req, 1'b0);
    chk("t1_valid", W_IR_valid, 1'b1);
    chk("t1_instr", I, 32'hA5A5_0000);
    chk("t1_pc",    pc_cur, 32'h0);

    // Continuous consumer, zero-wait memory: one instruction per cycle.
    reset_dut(0, 0);
    write_ir = 1;
    for (int i = 0; i < 10; i++) begin
      if (W_IR_valid) begin pop_cyc.push_back(cyc); pop_pc.push_back(pc_cur); end
      step();
    end
    write_ir = 0;
    chk("t2_npops", pop_pc.size(), 8);
    for (int k = 0; k < 4 && k < pop_pc.size(); k++) chk("t2_pc", pop_pc[k], 32'(k * 4));
    if (pop_cyc.size() >= 4) chk("t2_rate", pop_cyc[3] - pop_cyc[0], 3);

    // Redirect while the request to 0x8 is waiting on a slow memory.
    reset_dut(3, 3);
    write_ir = 1; found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (imem_req && !mbusy && imem_addr == 32'h8) found = 1;
      else step();
    end
    chk("t3_found", found, 1'b1);
    write_pc = 1; pc_next = 32'h100; write_ir = 0;
    step();
    write_pc = 0;
    n = req_log.size(); pending = !imem_ack; stab_err = 0; got = 0; first_pc = 32'hFFFF_FFFF;
    for (int i = 0; i < 15; i++) begin
      if (pending && (!imem_req || imem_addr != 32'h8)) stab_err++;
      if (W_IR_valid && !got) begin got = 1; first_pc = pc_cur; end
      step();
      if (imem_ack) pending = 0;
    end
    chk("t3_stable",   stab_err, 0);
    chk("t3_next_req", log_at(n), 32'h100);
    chk("t3_first_pc", first_pc, 32'h100);

    // Redirect, pop and ack all in one cycle.
    reset_dut(0, 0);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (W_IR_valid && imem_req) found = 1;
      else step();
    end
    chk("t4_found", found, 1'b1);
    write_pc = 1; pc_next = 32'h40; write_ir = 1;
    step();
    write_pc = 0; write_ir = 0;
    chk("t4_valid", W_IR_valid, 1'b0);
    chk("t4_req",   imem_req, 1'b1);
    chk("t4_addr",  imem_addr, 32'h40);
    got = 0; first_pc = 32'hFFFF_FFFF;
    for (int i = 0; i < 10 && !got; i++) begin
      if (W_IR_valid) begin got = 1; first_pc = pc_cur; end
      else step();
    end
    chk("t4_first_pc", first_pc, 32'h40);

    // Address wrap at the top of the space.
    reset_dut(0, 0);
    write_ir = 1;
    run(4);
    write_pc = 1; pc_next = 32'hFFFF_FFFC;
    step();
    write_pc = 0;
    n = req_log.size();
    run(6);
    write_ir = 0;
    chk("t5_req_top",  log_at(n), 32'hFFFF_FFFC);
    chk("t5_req_wrap", log_at(n + 1), 32'h0);

    // Misaligned redirect.
    reset_dut(0, 0);
    run(8);
    write_pc = 1; pc_next = 32'h102;
    step();
    write_pc = 0;
    n = req_log.size();
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("t6_fault_set", fetch_fault, 1'b1);
    run(6);
    chk("t6_no_req", req_log.size(), n);
    write_pc = 1; pc_next = 32'h200;
    step();
    write_pc = 0;
    chk("t6_fault_clr", fetch_fault, 1'b0);
    run(4);
    chk("t6_resume", log_at(n), 32'h200);
`else
    chk("t6_no_fault", fetch_fault, 1'b0);
    run(4);
    chk("t6_aligned", log_at(n), 32'h100);
`endif

    // Randomized traffic: latencies, consumer, redirects, stray acks, resets.
    reset_dut(0, 3);
    rand_data = 1; stray_en = 1;
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(199, 0) == 0);
      write_ir = ($urandom_range(9, 0) < 6);
      write_pc = ($urandom_range(19, 0) == 0);
      if ($urandom_range(3, 0) == 0) pc_next = 32'hFFFF_FFF0 + 32'($urandom_range(3, 0) * 4);
      else                           pc_next = 32'($urandom_range(255, 0) * 4);
      if ($urandom_range(7, 0) == 0) pc_next = pc_next | 32'($urandom_range(3, 0));
      step();
    end
    rst = 0; write_ir = 0; write_pc = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
